// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with load, wrap-or-saturate boundary handling,
// a registered boundary pulse and per-nibble seven-segment display outputs.

// Active-low seven-segment decoder for one hex nibble; seg[0] is segment a.
module seg7_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

module param_updown_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter longint unsigned  MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter bit               SATURATE  = 1'b0,
  localparam int unsigned     ND        = (WIDTH + 3) / 4
) (
  input  logic              clk,
  input  logic              rset,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic [7*ND-1:0]   hex
);

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             at_top, at_bottom;
  logic [4*ND-1:0]  q_pad;

  assign at_top    = (q_q == MaxCnt);
  assign at_bottom = (q_q == '0);

  // Load wins over counting; a boundary step raises tc whether it wraps or holds.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (load) begin
      q_d = (load_val > MaxCnt) ? MaxCnt : load_val;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          tc_d = 1'b1;
          q_d  = SATURATE ? q_q : '0;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_bottom) begin
          tc_d = 1'b1;
          q_d  = SATURATE ? q_q : MaxCnt;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q  = q_q;
  assign tc = tc_q;

  // Zero-extend so the top digit sees a full nibble when WIDTH is not a multiple of 4.
  always_comb begin
    q_pad            = '0;
    q_pad[WIDTH-1:0] = q_q;
  end

  for (genvar k = 0; k < ND; k++) begin : g_digit
    seg7_decoder u_dec (
      .nibble (q_pad[4*k +: 4]),
      .seg    (hex[7*k +: 7])
    );
  end

endmodule
